// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: IDLE/HOLD/RUN/DONE control with relative branches.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_sequencer #(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                halt,
  input  logic                branch_taken,
  input  logic [7:0]          branch_offset,
  output logic [PC_WIDTH-1:0] pc,
  output logic                run_en,
  output logic                done,
  output logic [15:0]         cycle_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [PC_WIDTH-1:0] pc_r;
  logic [PC_WIDTH-1:0] pc_nxt_s;
  logic                done_r;
  logic                done_nxt_s;
  logic                run_start_s;

  // Bits above the offset width replicate its sign bit.
  function automatic logic [PC_WIDTH-1:0] sext_offset(input logic [7:0] off);
    logic [PC_WIDTH-1:0] r;
    for (int i = 0; i < PC_WIDTH; i++) begin
      r[i] = off[(i < 8) ? i : 7];
    end
    return r;
  endfunction

  // Next-state, next-pc and done decode.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    done_nxt_s  = done_r;
    run_start_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = HOLD;
          pc_nxt_s    = {PC_WIDTH{1'b0}};
        end else begin
          state_nxt_s = IDLE;
        end
      end
      HOLD: begin
        pc_nxt_s = {PC_WIDTH{1'b0}};
        if (!start) begin
          state_nxt_s = RUN;
          run_start_s = 1'b1;
        end else begin
          state_nxt_s = HOLD;
        end
      end
      RUN: begin
        if (halt) begin
          state_nxt_s = DONE;
          done_nxt_s  = 1'b1;
        end else if (branch_taken) begin
          pc_nxt_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1} + sext_offset(branch_offset);
        end else begin
          pc_nxt_s = pc_r + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        if (start) begin
          state_nxt_s = HOLD;
          done_nxt_s  = 1'b0;
          pc_nxt_s    = {PC_WIDTH{1'b0}};
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        pc_nxt_s    = {PC_WIDTH{1'b0}};
        done_nxt_s  = 1'b0;
      end
    endcase
  end

  // State, pc and done registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      pc_r    <= {PC_WIDTH{1'b0}};
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

  assign pc     = pc_r;
  assign done   = done_r;
  assign run_en = (state_r == RUN);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt_r;

  // Saturating RUN-cycle counter, cleared when a program starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= 16'h0000;
    end else if (run_start_s) begin
      cnt_r <= 16'h0000;
    end else if ((state_r == RUN) && (cnt_r != 16'hFFFF)) begin
      cnt_r <= cnt_r + 16'h0001;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cycle_count = cnt_r;
`else
  logic unused_run_start_s;
  assign unused_run_start_s = run_start_s;
  assign cycle_count        = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a per-cycle reference model.
module tb_fetch_sequencer;

  localparam int PCW   = 10;
  localparam int DEPTH = 1 << PCW;
`ifdef FETCH_CYCLE_COUNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           halt = 1'b0;
  logic           branch_taken = 1'b0;
  logic [7:0]     branch_offset = 8'h00;
  logic [PCW-1:0] pc;
  logic           run_en;
  logic           done;
  logic [15:0]    cycle_count;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.PC_WIDTH(PCW)) dut (
    .clk(clk), .reset(reset), .start(start), .halt(halt),
    .branch_taken(branch_taken), .branch_offset(branch_offset),
    .pc(pc), .run_en(run_en), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: states as plain names, pc as integer mod DEPTH.
  typedef enum int { M_IDLE, M_HOLD, M_RUN, M_DONE } mstate_t;
  mstate_t m_st = M_IDLE;
  int      m_pc = 0;
  int      m_done = 0;
  int      m_cnt = 0;
  bit      m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_st = M_IDLE; m_pc = 0; m_done = 0; m_cnt = 0; m_valid = 1'b1;
    end else begin
      case (m_st)
        M_IDLE: if (start) m_st = M_HOLD;
        M_HOLD: begin
          m_pc = 0;
          if (!start) begin m_st = M_RUN; m_cnt = 0; end
        end
        M_RUN: begin
          if (m_cnt < 65535) m_cnt = m_cnt + 1;
          if (halt) begin
            m_st = M_DONE; m_done = 1;
          end else begin
            int off;
            off  = branch_taken ? int'($signed(branch_offset)) : 0;
            m_pc = (((m_pc + 1 + off) % DEPTH) + DEPTH) % DEPTH;
          end
        end
        M_DONE: if (start) begin m_st = M_HOLD; m_done = 0; m_pc = 0; end
        default: m_st = M_IDLE;
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("pc", int'(pc), m_pc);
      chk("run_en", int'(run_en), (m_st == M_RUN) ? 1 : 0);
      chk("done", int'(done), m_done);
      chk("cycle_count", int'(cycle_count), CNT_ON ? m_cnt : 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset state
    ticks(2);
    chk("rst_pc", int'(pc), 0);
    chk("rst_run_en", int'(run_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cnt", int'(cycle_count), 0);

    // start held 3 cycles, then release into RUN
    reset = 1'b0; start = 1'b1;
    ticks(3);
    chk("hold_pc", int'(pc), 0);
    chk("hold_run_en", int'(run_en), 0);
    start = 1'b0;
    tick();
    chk("run0_pc", int'(pc), 0);
    chk("run0_run_en", int'(run_en), 1);
    tick(); chk("run_pc1", int'(pc), 1);
    start = 1'b1;                      // ignored in RUN
    tick(); chk("run_pc2", int'(pc), 2);
    start = 1'b0;
    tick(); chk("run_pc3", int'(pc), 3);
    ticks(2); chk("run_pc5", int'(pc), 5);

    // relative branches
    branch_taken = 1'b1; branch_offset = 8'hFD;
    tick(); chk("br_back", int'(pc), 3);
    branch_offset = 8'h04;
    tick(); chk("br_fwd", int'(pc), 8);
    branch_offset = 8'hF7;
    tick(); chk("br_to0", int'(pc), 0);
    branch_offset = 8'hFE;
    tick(); chk("wrap_down", int'(pc), 1023);
    branch_taken = 1'b0;
    tick(); chk("wrap_up", int'(pc), 0);

    // halt to DONE, then restart from DONE
    halt = 1'b1;
    tick();
    halt = 1'b0;
    chk("done1", int'(done), 1);
    chk("done1_pc", int'(pc), 0);
    start = 1'b1;
    tick();
    chk("restart_done", int'(done), 0);
    chk("restart_pc", int'(pc), 0);
    chk("restart_run_en", int'(run_en), 0);
    start = 1'b0;
    tick();
    chk("restart_run0", int'(pc), 0);
    chk("restart_run_en1", int'(run_en), 1);
    ticks(7);
    chk("pre_halt_pc", int'(pc), 7);

    // halt beats branch
    halt = 1'b1; branch_taken = 1'b1; branch_offset = 8'h10;
    tick();
    chk("halt_done", int'(done), 1);
    chk("halt_run_en", int'(run_en), 0);
    chk("halt_pc", int'(pc), 7);
    chk("halt_cnt", int'(cycle_count), CNT_ON ? 8 : 0);
    ticks(2);                          // halt/branch ignored in DONE
    chk("done_hold_pc", int'(pc), 7);
    chk("done_hold_cnt", int'(cycle_count), CNT_ON ? 8 : 0);
    halt = 1'b0; branch_taken = 1'b0;

    // run to pc=12, then reset with start asserted
    start = 1'b1; tick();
    start = 1'b0; tick();
    ticks(12);
    chk("mid_pc", int'(pc), 12);
    reset = 1'b1; start = 1'b1; halt = 1'b1; branch_taken = 1'b1;
    tick();
    chk("mrst_pc", int'(pc), 0);
    chk("mrst_done", int'(done), 0);
    chk("mrst_run_en", int'(run_en), 0);
    chk("mrst_cnt", int'(cycle_count), 0);
    reset = 1'b0; start = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    ticks(2);
    chk("idle_run_en", int'(run_en), 0);
    start = 1'b1; tick();
    start = 1'b0; tick();
    chk("rerun_pc", int'(pc), 0);
    chk("rerun_run_en", int'(run_en), 1);
    ticks(3);
    chk("rerun_pc3", int'(pc), 3);

    @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
